// File: rtl/vwb_pkg.sv
// Shared types and sizing helpers for the vwb_gemm host-side driver.
package vwb_pkg;

  localparam int IN_VEC_LEN  = 48;
  localparam int OUT_VEC_LEN = 11;
  localparam int NBITS       = 12;

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_READ    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DRAIN   = 3'd5
  } state_e;

  typedef logic [NBITS-1:0] elem_t;

  // Counter width that still works for a length of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = cnt_w(IN_VEC_LEN);
  localparam int ODX_W = cnt_w(OUT_VEC_LEN);

endpackage

// File: rtl/vec_serializer.sv
// Parallel-load result register streamed out as scalars over valid/ready with a last flag.
module vec_serializer
  import vwb_pkg::*;
#(
  parameter int N     = OUT_VEC_LEN,
  parameter int NBits = NBITS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [N-1:0][NBits-1:0]   vec_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [NBits-1:0]          data_o,
  output logic                      last_o
);

  localparam int                ODX_W_L  = cnt_w(N);
  localparam logic [ODX_W_L-1:0] ODX_LAST = ODX_W_L'(N - 1);

  logic [N-1:0][NBits-1:0] res_q;
  logic [ODX_W_L-1:0]      odx_q;
  logic [ODX_W_L-1:0]      odx_nxt;
  logic                    valid_q;
  logic [NBits-1:0]        data_q;
  logic                    last_q;

  assign odx_nxt = odx_q + ODX_W_L'(1);

  // Output element is pre-selected into a register so m_data/m_last hold during stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q   <= '0;
      odx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      res_q   <= vec_i;
      odx_q   <= '0;
      valid_q <= 1'b1;
      data_q  <= vec_i[0];
      last_q  <= (N == 1);
    end else if (valid_q && ready_i) begin
      if (last_q) begin
        odx_q   <= '0;
        valid_q <= 1'b0;
        data_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        odx_q   <= odx_nxt;
        data_q  <= res_q[odx_nxt];
        last_q  <= (odx_nxt == ODX_LAST);
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/vwb_gemm_host.sv
// Host driver: packs a scalar stream into one GEMM input vector, issues it, then
// pops the GEMM result vector and streams it back out as scalars.
module vwb_gemm_host
  import vwb_pkg::*;
#(
  parameter int InVecLength  = IN_VEC_LEN,
  parameter int OutVecLength = OUT_VEC_LEN,
  parameter int NBits        = NBITS
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [NBits-1:0]                    s_data,
  output logic                                in_data_ready,
  output logic [InVecLength-1:0][NBits-1:0]   in_data_top,
  input  logic                                module_ready,
  input  logic                                out_data_valid,
  output logic                                rd_out_top,
  input  logic [OutVecLength-1:0][NBits-1:0]  out_data_top,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [NBits-1:0]                    m_data,
  output logic                                m_last,
  output logic                                busy,
  output logic                                proto_err
);

  localparam int                 IDX_W_L  = cnt_w(InVecLength);
  localparam logic [IDX_W_L-1:0] IDX_LAST = IDX_W_L'(InVecLength - 1);

  state_e                          state_q;
  logic [IDX_W_L-1:0]              idx_q;
  logic [InVecLength-1:0][NBits-1:0] vec_q;
  logic                            s_ready_q;
  logic                            busy_q;
  logic                            idr_q;
  logic                            rd_q;
  logic                            perr_q;

  logic                            ser_load;
  logic                            ser_valid;
  logic [NBits-1:0]                ser_data;
  logic                            ser_last;

  // Main control FSM; s_ready/busy are registered alongside the state they decode.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_FILL;
      idx_q     <= '0;
      vec_q     <= '0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      idr_q     <= 1'b0;
      rd_q      <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      idr_q <= 1'b0;
      rd_q  <= 1'b0;
      if (out_data_valid && (state_q != ST_WAIT)) begin
        perr_q <= 1'b1;
      end
      case (state_q)
        ST_FILL: begin
          if (s_valid) begin
            vec_q[idx_q] <= s_data;
            if (idx_q == IDX_LAST) begin
              idx_q     <= '0;
              state_q   <= ST_ISSUE;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W_L'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (module_ready) begin
            idr_q   <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (out_data_valid) begin
            rd_q    <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (ser_valid && m_ready && ser_last) begin
            state_q   <= ST_FILL;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_FILL;
          idx_q     <= '0;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // The GEMM drives out_data_top one cycle after the pop, i.e. during CAPTURE.
  assign ser_load = (state_q == ST_CAPTURE);

  vec_serializer #(
    .N     (OutVecLength),
    .NBits (NBits)
  ) u_ser (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .load_i  (ser_load),
    .vec_i   (out_data_top),
    .ready_i (m_ready),
    .valid_o (ser_valid),
    .data_o  (ser_data),
    .last_o  (ser_last)
  );

  assign s_ready       = s_ready_q;
  assign busy          = busy_q;
  assign in_data_ready = idr_q;
  assign in_data_top   = vec_q;
  assign rd_out_top    = rd_q;
  assign proto_err     = perr_q;
  assign m_valid       = ser_valid;
  assign m_data        = ser_data;
  assign m_last        = ser_last;

endmodule

// File: tb/tb_vwb_gemm_host.sv
// Self-checking bench for vwb_gemm_host: table-driven transactions plus
// hand-written protocol-error and mid-drain reset sequences.
module tb_vwb_gemm_host;

  localparam int IN_N  = 48;
  localparam int OUT_N = 11;
  localparam int NB    = 12;

  logic                      clk_in = 1'b0;
  logic                      rst_in;
  logic                      s_valid;
  logic                      s_ready;
  logic [NB-1:0]             s_data;
  logic                      in_data_ready;
  logic [IN_N-1:0][NB-1:0]   in_data_top;
  logic                      module_ready;
  logic                      out_data_valid;
  logic                      rd_out_top;
  logic [OUT_N-1:0][NB-1:0]  out_data_top;
  logic                      m_valid;
  logic                      m_ready;
  logic [NB-1:0]             m_data;
  logic                      m_last;
  logic                      busy;
  logic                      proto_err;

  vwb_gemm_host dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .in_data_ready  (in_data_ready),
    .in_data_top    (in_data_top),
    .module_ready   (module_ready),
    .out_data_valid (out_data_valid),
    .rd_out_top     (rd_out_top),
    .out_data_top   (out_data_top),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .proto_err      (proto_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int            fill_base;
    int            mr_delay;
    int            res_base;
    int            rdy_pct;
    logic [NB-1:0] exp_first;
    logic [NB-1:0] exp_last;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int issue_cnt = 0;
  int rd_cnt = 0;
  logic prev_idr = 1'b0;
  logic prev_rd = 1'b0;
  logic hold_pend = 1'b0;
  logic [NB-1:0] hold_data;
  logic hold_last;
  logic [NB-1:0] sb_q[$];
  logic [IN_N-1:0][NB-1:0] exp_vec;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic check_vec(input string nm);
    n_cmp++;
    if (in_data_top !== exp_vec) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, in_data_top, exp_vec);
    end
  endtask

  // One clock: per-cycle protocol and scoreboard checks on the current cycle, then advance.
  task automatic step();
    logic [NB-1:0] e;
    if (!rst_in) begin
      if (hold_pend) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, hold_data);
        check("stall_last", m_last, hold_last);
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
      check("pulse_overlap", in_data_ready & rd_out_top, 0);
      if (in_data_ready) begin
        issue_cnt++;
        check("idr_consecutive", prev_idr, 0);
      end
      if (rd_out_top) begin
        rd_cnt++;
        check("rd_consecutive", prev_rd, 0);
      end
      prev_idr = in_data_ready;
      prev_rd  = rd_out_top;
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_m_data", m_data, 0);
          check("unexpected_m_valid", m_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("m_data", m_data, e);
          check("m_last", m_last, (sb_q.size() == 0));
        end
      end
    end else begin
      hold_pend = 1'b0;
      prev_idr  = 1'b0;
      prev_rd   = 1'b0;
    end
    @(posedge clk_in);
    #1;
    cycle++;
    if (cycle > 60000) begin
      $display("FAIL global_timeout: cycle %0d", cycle);
      $fatal(1, "timeout");
    end
  endtask

  task automatic check_reset();
    check("rst_s_ready", s_ready, 1);
    check("rst_in_data_ready", in_data_ready, 0);
    check("rst_rd_out_top", rd_out_top, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    exp_vec = '0;
    check_vec("rst_in_data_top");
  endtask

  // Feed IN_N samples base, base+1, ...; optionally pulse out_data_valid during one accept.
  task automatic fill(input int base, input int odv_at);
    int g;
    for (int i = 0; i < IN_N; i++) begin
      exp_vec[i] = NB'(base + i);
    end
    s_valid = 1'b1;
    for (int i = 0; i < IN_N; i++) begin
      s_data = NB'(base + i);
      g = 0;
      while (!s_ready && g < 100) begin
        step();
        g++;
      end
      check("fill_s_ready", s_ready, 1);
      check("fill_busy", busy, 0);
      if (i == odv_at) out_data_valid = 1'b1;
      step();
      out_data_valid = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = 12'h5A5;
  endtask

  // Cycle t+1 on entry (ISSUE); hold module_ready low for mr_delay cycles.
  task automatic issue(input int mr_delay, input logic [NB-1:0] ef, input logic [NB-1:0] el);
    module_ready = 1'b0;
    check("issue_s_ready", s_ready, 0);
    check("issue_busy", busy, 1);
    for (int d = 0; d < mr_delay; d++) begin
      check("stall_no_idr", in_data_ready, 0);
      check_vec("stall_vec");
      step();
    end
    module_ready = 1'b1;
    check("pre_idr", in_data_ready, 0);
    step();
    check("idr_pulse", in_data_ready, 1);
    check("vec_first", in_data_top[0], ef);
    check("vec_last", in_data_top[IN_N-1], el);
    check_vec("issued_vec");
    module_ready = 1'b0;
  endtask

  task automatic result(input int res_base, input int pct);
    int cnt;
    s_valid = 1'b0;
    for (int k = 0; k < OUT_N; k++) begin
      out_data_top[k] = NB'(res_base + k);
    end
    for (int w = 0; w < 3; w++) begin
      step();
      check("wait_no_rd", rd_out_top, 0);
      check("wait_s_ready", s_ready, 0);
      check_vec("wait_vec");
    end
    for (int k = 0; k < OUT_N; k++) sb_q.push_back(NB'(res_base + k));
    out_data_valid = 1'b1;
    step();
    out_data_valid = 1'b0;
    check("rd_u1", rd_out_top, 1);
    step();
    check("rd_u2", rd_out_top, 0);
    check("m_valid_u2", m_valid, 0);
    step();
    check("m_valid_u3", m_valid, 1);
    check("m_data_u3", m_data, NB'(res_base));
    check_vec("drain_vec");
    cnt = 0;
    while (sb_q.size() > 0 && cnt < 500) begin
      m_ready = ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
      step();
      cnt++;
    end
    check("drain_complete", sb_q.size(), 0);
    m_ready = 1'b0;
    if (pct >= 100) begin
      check("drain_cycles", cnt, OUT_N);
    end
    check("fill_resumes", s_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_m_valid", m_valid, 0);
  endtask

  txn_t tbl[3];
  int rd_snap;
  int iss_snap;
  int g2;

  initial begin
    tbl[0] = '{fill_base: 1,   mr_delay: 0,  res_base: 100,  rdy_pct: 100, exp_first: 12'd1,   exp_last: 12'd48};
    tbl[1] = '{fill_base: 200, mr_delay: 20, res_base: 500,  rdy_pct: 50,  exp_first: 12'd200, exp_last: 12'd247};
    tbl[2] = '{fill_base: -24, mr_delay: 3,  res_base: 2040, rdy_pct: 30,  exp_first: 12'hFE8, exp_last: 12'd23};

    rst_in         = 1'b1;
    s_valid        = 1'b0;
    s_data         = '0;
    module_ready   = 1'b0;
    out_data_valid = 1'b0;
    out_data_top   = '0;
    m_ready        = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    check_reset();

    for (int t = 0; t < 3; t++) begin
      fill(tbl[t].fill_base, -1);
      issue(tbl[t].mr_delay, tbl[t].exp_first, tbl[t].exp_last);
      result(tbl[t].res_base, tbl[t].rdy_pct);
    end
    check("issue_count_tbl", issue_cnt, 3);
    check("proto_err_clean", proto_err, 0);

    // out_data_valid during FILL: sticky error, no pop, fill unaffected.
    rd_snap = rd_cnt;
    fill(700, 10);
    check("perr_set", proto_err, 1);
    check("perr_no_rd", rd_cnt, rd_snap);
    issue(0, 12'd700, 12'd747);
    result(900, 100);
    check("perr_sticky", proto_err, 1);
    check("perr_rd_once", rd_cnt, rd_snap + 1);

    // Reset in the middle of DRAIN after five elements.
    fill(300, -1);
    issue(0, 12'd300, 12'd347);
    s_valid = 1'b0;
    for (int k = 0; k < OUT_N; k++) out_data_top[k] = NB'(1000 + k);
    for (int k = 0; k < OUT_N; k++) sb_q.push_back(NB'(1000 + k));
    step();
    out_data_valid = 1'b1;
    step();
    out_data_valid = 1'b0;
    step();
    step();
    m_ready = 1'b1;
    g2 = 0;
    while (sb_q.size() > OUT_N - 5 && g2 < 50) begin
      step();
      g2++;
    end
    check("mid_drain_count", sb_q.size(), OUT_N - 5);
    check("mid_drain_valid", m_valid, 1);
    m_ready = 1'b0;
    rst_in  = 1'b1;
    step();
    rst_in  = 1'b0;
    sb_q.delete();
    check_reset();
    iss_snap = issue_cnt;
    rd_snap  = rd_cnt;
    fill(400, -1);
    issue(0, 12'd400, 12'd447);
    module_ready = 1'b1;
    for (int w = 0; w < 10; w++) step();
    check("post_rst_one_issue", issue_cnt - iss_snap, 1);
    check("post_rst_no_rd", rd_cnt, rd_snap);

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
